// File: rtl/audio_pkg.sv
// Shared audio definitions: sample width, mono source selectors and the
// receiver's state / channel encodings.
package audio_pkg;

  localparam int AUDIO_W = 16;

  localparam int MONO_LEFT  = 0;
  localparam int MONO_RIGHT = 1;
  localparam int MONO_AVG   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } rx_state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

endpackage

// File: rtl/i2s_adc_rx_if.sv
// Codec-side serial pins plus the parallel PCM results of the I2S receiver.
interface i2s_adc_rx_if
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W
);

  logic              AUD_BCLK;
  logic              AUD_ADCLRCK;
  logic              AUD_ADCDAT;
  logic [DATA_W-1:0] left_out;
  logic [DATA_W-1:0] right_out;
  logic [DATA_W-1:0] audio_out;
  logic              sample_valid;
  logic              frame_err;

  modport master (
    output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    input  left_out, right_out, audio_out, sample_valid, frame_err
  );

  modport slave (
    input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    output left_out, right_out, audio_out, sample_valid, frame_err
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous level, with one-cycle
// rise/fall pulses derived from the synchronized value and its delayed copy.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// WM8731 ADC I2S receiver: oversamples BCLK/LRCK in the CLK domain, shifts
// DATA_W bits per channel and publishes a left/right/mono triple per pair.
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUDIO_W,
  parameter int SYNC_STAGES = 2,
  parameter int MONO_SEL    = MONO_LEFT
) (
  input  logic           CLK,
  input  logic           RST,
  i2s_adc_rx_if.slave    aud
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic bclk_rise, lr_rise, lr_fall, lr_edge, dat_bit;
  logic bclk_lvl_unused, bclk_fall_unused, lr_lvl_unused;
  logic dat_rise_unused, dat_fall_unused;

  // Data rides the same synchronizer depth as BCLK so the bit is phase-aligned with bclk_rise.
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk(CLK), .rst_n(RST), .d_i(aud.AUD_BCLK),
    .sync_o(bclk_lvl_unused), .rise_o(bclk_rise), .fall_o(bclk_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk(CLK), .rst_n(RST), .d_i(aud.AUD_ADCLRCK),
    .sync_o(lr_lvl_unused), .rise_o(lr_rise), .fall_o(lr_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_dat_sync (
    .clk(CLK), .rst_n(RST), .d_i(aud.AUD_ADCDAT),
    .sync_o(dat_bit), .rise_o(dat_rise_unused), .fall_o(dat_fall_unused)
  );

  assign lr_edge = lr_rise | lr_fall;

  rx_state_t         state_q;
  chan_t             ch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q, hold_l_q;
  logic              commit_q;
  logic [DATA_W-1:0] left_q, right_q, audio_q;
  logic              valid_q, ferr_q;

  logic [DATA_W-1:0] shift_d, mono_d, avg_d;
  logic [DATA_W:0]   sum_d;
  logic              expect_edge_d;

  // Average uses a sign-extended DATA_W+1 sum so the arithmetic shift floors correctly.
  always_comb begin
    shift_d       = {shreg_q[DATA_W-2:0], dat_bit};
    sum_d         = {hold_l_q[DATA_W-1], hold_l_q} + {shreg_q[DATA_W-1], shreg_q};
    avg_d         = DATA_W'($signed(sum_d) >>> 1);
    expect_edge_d = (ch_q == CH_LEFT) ? lr_rise : lr_fall;
    case (MONO_SEL)
      MONO_RIGHT: mono_d = shreg_q;
      MONO_AVG:   mono_d = avg_d;
      default:    mono_d = hold_l_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      ch_q     <= CH_LEFT;
      cnt_q    <= '0;
      shreg_q  <= '0;
      hold_l_q <= '0;
      commit_q <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      commit_q <= 1'b0;
      if (commit_q) begin
        left_q  <= hold_l_q;
        right_q <= shreg_q;
        audio_q <= mono_d;
        valid_q <= 1'b1;
      end
      // An LRCK edge coinciding with bclk_rise consumes that bit as the I2S delay slot.
      case (state_q)
        IDLE: begin
          if (lr_fall) begin
            ch_q    <= CH_LEFT;
            cnt_q   <= '0;
            state_q <= bclk_rise ? SHIFT : SKIP;
          end
        end
        SKIP: begin
          if (lr_edge) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end else if (bclk_rise) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (lr_edge) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end else if (bclk_rise) begin
            shreg_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_q <= WAIT;
              if (ch_q == CH_LEFT) hold_l_q <= shift_d;
              else                 commit_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (expect_edge_d) begin
            ch_q    <= (ch_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
            cnt_q   <= '0;
            state_q <= bclk_rise ? SHIFT : SKIP;
          end else if (lr_edge) begin
            ferr_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign aud.left_out     = left_q;
  assign aud.right_out    = right_q;
  assign aud.audio_out    = audio_q;
  assign aud.sample_valid = valid_q;
  assign aud.frame_err    = ferr_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: a behavioural I2S codec feeds a left-mono
// and an averaging receiver; a negedge monitor records every output pulse.
module tb_i2s_adc_rx;
  import audio_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk = 1'b0;
  logic lrck = 1'b1;
  logic adcdat = 1'b0;

  always #10 clk = ~clk;

  i2s_adc_rx_if #(.DATA_W(W)) bus0 ();
  i2s_adc_rx_if #(.DATA_W(W)) bus2 ();

  assign bus0.AUD_BCLK    = bclk;
  assign bus0.AUD_ADCLRCK = lrck;
  assign bus0.AUD_ADCDAT  = adcdat;
  assign bus2.AUD_BCLK    = bclk;
  assign bus2.AUD_ADCLRCK = lrck;
  assign bus2.AUD_ADCDAT  = adcdat;

  i2s_adc_rx #(.DATA_W(W), .SYNC_STAGES(2), .MONO_SEL(MONO_LEFT)) dut0 (
    .CLK(clk), .RST(rst_n), .aud(bus0)
  );

  i2s_adc_rx #(.DATA_W(W), .SYNC_STAGES(2), .MONO_SEL(MONO_AVG)) dut2 (
    .CLK(clk), .RST(rst_n), .aud(bus2)
  );

  int checks = 0;
  int fails = 0;
  int validCount = 0;
  int valid2Count = 0;
  int errCount = 0;
  int expValid = 0;
  int ratio = 16;
  int lrSkew = 0;
  logic [W-1:0] lastL = '0, lastR = '0, lastA0 = '0, lastA2 = '0;

  always @(negedge clk) begin
    if (bus0.sample_valid) begin
      validCount <= validCount + 1;
      lastL      <= bus0.left_out;
      lastR      <= bus0.right_out;
      lastA0     <= bus0.audio_out;
    end
    if (bus2.sample_valid) begin
      valid2Count <= valid2Count + 1;
      lastA2      <= bus2.audio_out;
    end
    if (bus0.frame_err || bus2.frame_err) errCount <= errCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One codec channel: LRCK and data change on BCLK fall, MSB one BCLK after the LRCK edge.
  task automatic applyStimulus(input logic lr, input logic [W-1:0] word, input int nPer);
    int lowT, highT;
    lowT  = ((ratio + 1) / 2) * 20;
    highT = (ratio / 2) * 20;
    for (int k = 0; k < nPer; k++) begin
      bclk = 1'b0;
      if (k >= 1 && k <= W) adcdat = word[W-k];
      else                  adcdat = 1'($urandom_range(0, 1));
      if (k == 0 && lrSkew > 0) begin
        #(lowT - lrSkew);
        lrck = lr;
        #(lrSkew);
      end else begin
        if (k == 0) lrck = lr;
        #(lowT);
      end
      bclk = 1'b1;
      #(highT);
    end
  endtask

  task automatic applyPair(input logic [W-1:0] l, input logic [W-1:0] r);
    applyStimulus(1'b0, l, 32);
    applyStimulus(1'b1, r, 32);
  endtask

  task automatic checkPair(input string tag, input int v0, input logic [W-1:0] l,
                           input logic [W-1:0] r, input logic [W-1:0] avg);
    checkOutput({tag, "_count"}, validCount - v0, 1);
    checkOutput({tag, "_left"}, lastL, l);
    checkOutput({tag, "_right"}, lastR, r);
    checkOutput({tag, "_mono0"}, lastA0, l);
    checkOutput({tag, "_mono2"}, lastA2, avg);
  endtask

  logic [W-1:0] tabL [3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
  logic [W-1:0] tabR [3] = '{16'h7FFF, 16'h7FFF, 16'h0000};
  logic [W-1:0] tabA [3] = '{16'h7FFF, 16'hFFFF, 16'hFFFF};

  initial begin
    int v, e, si;
    logic [W-1:0] rl, rr, ra;

    repeat (3) @(posedge clk);
    #7;
    checkOutput("rst_left", bus0.left_out, 0);
    checkOutput("rst_right", bus0.right_out, 0);
    checkOutput("rst_audio", bus0.audio_out, 0);
    checkOutput("rst_valid", bus0.sample_valid, 0);
    checkOutput("rst_ferr", bus0.frame_err, 0);
    rst_n = 1'b1;
    #(80);

    v = validCount;
    applyPair(16'h1234, 16'hABCD);
    expValid++;
    checkPair("t1", v, 16'h1234, 16'hABCD, 16'hDF00);

    for (int i = 0; i < 3; i++) begin
      v = validCount;
      applyPair(tabL[i], tabR[i]);
      expValid++;
      checkPair($sformatf("t2_%0d", i), v, tabL[i], tabR[i], tabA[i]);
    end

    // Reset held through the left word and released in the middle of the right word.
    v = validCount;
    e = errCount;
    rst_n = 1'b0;
    fork
      applyPair(16'h1111, 16'h2222);
      begin
        #((32 + 5) * ratio * 20);
        rst_n = 1'b1;
      end
    join
    checkOutput("t3_novalid", validCount - v, 0);
    checkOutput("t3_noerr", errCount - e, 0);
    checkOutput("t3_left_cleared", bus0.left_out, 0);
    v = validCount;
    applyPair(16'h3333, 16'h4444);
    expValid++;
    checkPair("t3", v, 16'h3333, 16'h4444, 16'h3BBB);

    v = validCount;
    e = errCount;
    applyStimulus(1'b0, 16'hBEEF, 10);
    applyStimulus(1'b1, 16'h5555, 32);
    checkOutput("t4_ferr", errCount - e, 1);
    checkOutput("t4_novalid", validCount - v, 0);
    checkOutput("t4_left_held", bus0.left_out, 16'h3333);
    checkOutput("t4_right_held", bus0.right_out, 16'h4444);
    v = validCount;
    applyPair(16'h0F0F, 16'hF0F0);
    expValid++;
    checkPair("t4", v, 16'h0F0F, 16'hF0F0, 16'hFFFF);
    checkOutput("t4_ferr_once", errCount - e, 1);

    v = validCount;
    e = errCount;
    fork
      applyPair(16'h1357, 16'h2468);
      begin
        #(8 * ratio * 20 + 5);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_left_zero", bus0.left_out, 0);
        checkOutput("t5_right_zero", bus0.right_out, 0);
        checkOutput("t5_audio_zero", bus2.audio_out, 0);
        #(3 * 20 - 1);
        rst_n = 1'b1;
      end
    join
    checkOutput("t5_novalid", validCount - v, 0);
    checkOutput("t5_noerr", errCount - e, 0);
    v = validCount;
    applyPair(16'h2468, 16'h1357);
    expValid++;
    checkPair("t5", v, 16'h2468, 16'h1357, 16'h1BDF);

    // Ratio sweep with alternating LRCK-before-BCLK skew to force coincident edges.
    e = errCount;
    for (int pass = 0; pass < 2; pass++) begin
      ratio = (pass == 0) ? 4 : 17;
      for (int i = 0; i < ((pass == 0) ? 24 : 6); i++) begin
        rl = W'($urandom);
        rr = W'($urandom);
        si = int'($signed(rl)) + int'($signed(rr));
        ra = W'(si >>> 1);
        lrSkew = (i % 2 == 1) ? 3 : 0;
        v = validCount;
        applyPair(rl, rr);
        expValid++;
        checkPair($sformatf("t6_r%0d_%0d", ratio, i), v, rl, rr, ra);
      end
    end
    lrSkew = 0;
    checkOutput("t6_noerr", errCount - e, 0);
    checkOutput("valid_total", validCount, expValid);
    checkOutput("valid2_total", valid2Count, expValid);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
